// File: rtl/gps_l1_sig_gen.sv
// gps_l1_sig_gen: synthetic GPS L1 C/A baseband source.
// Emits 1-bit I/Q samples with a one-cycle adc_clk strobe for a selected PRN,
// initial code phase and carrier Doppler step. A code NCO paces the chips and
// a 16-bit carrier phase accumulator rotates the I/Q signs.
// Optional feature: define GPS_SIGGEN_NOISE_EN to add the noise_level input and
// a sign-flipping noise LFSR. The default build produces clean output.
module gps_l1_sig_gen #(
  parameter int unsigned        SAMPLE_DIV = 2,
  parameter logic        [31:0] CODE_STEP  = 32'd1098437886,
  parameter logic signed [15:0] IF_STEP    = 16'sd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic        [5:0]  prn,
  input  logic        [9:0]  code_phase,
  input  logic signed [15:0] doppler_omega,
`ifdef GPS_SIGGEN_NOISE_EN
  input  logic        [7:0]  noise_level,
`endif
  output logic               adc_clk,
  output logic               i_sample,
  output logic               q_sample,
  output logic               epoch,
  output logic               busy
);

  localparam int unsigned      CNT_W     = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [9:0]       CHIP_LAST = 10'd1022;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADVANCE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  // G2 phase-select taps for PRN 1..32, returned as a mask over G2 stages 10..1.
  function automatic logic [10:1] g2_sel_mask(input logic [5:0] p);
    logic [7:0]  ab;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [10:1] m;
    case (p)
      6'd1:    ab = {4'd2, 4'd6};
      6'd2:    ab = {4'd3, 4'd7};
      6'd3:    ab = {4'd4, 4'd8};
      6'd4:    ab = {4'd5, 4'd9};
      6'd5:    ab = {4'd1, 4'd9};
      6'd6:    ab = {4'd2, 4'd10};
      6'd7:    ab = {4'd1, 4'd8};
      6'd8:    ab = {4'd2, 4'd9};
      6'd9:    ab = {4'd3, 4'd10};
      6'd10:   ab = {4'd2, 4'd3};
      6'd11:   ab = {4'd3, 4'd4};
      6'd12:   ab = {4'd5, 4'd6};
      6'd13:   ab = {4'd6, 4'd7};
      6'd14:   ab = {4'd7, 4'd8};
      6'd15:   ab = {4'd8, 4'd9};
      6'd16:   ab = {4'd9, 4'd10};
      6'd17:   ab = {4'd1, 4'd4};
      6'd18:   ab = {4'd2, 4'd5};
      6'd19:   ab = {4'd3, 4'd6};
      6'd20:   ab = {4'd4, 4'd7};
      6'd21:   ab = {4'd5, 4'd8};
      6'd22:   ab = {4'd6, 4'd9};
      6'd23:   ab = {4'd1, 4'd3};
      6'd24:   ab = {4'd4, 4'd6};
      6'd25:   ab = {4'd5, 4'd7};
      6'd26:   ab = {4'd6, 4'd8};
      6'd27:   ab = {4'd7, 4'd9};
      6'd28:   ab = {4'd8, 4'd10};
      6'd29:   ab = {4'd1, 4'd6};
      6'd30:   ab = {4'd2, 4'd7};
      6'd31:   ab = {4'd3, 4'd8};
      6'd32:   ab = {4'd4, 4'd9};
      default: ab = {4'd1, 4'd1};
    endcase
    a = ab[7:4];
    b = ab[3:0];
    // Stage k of the [10:1] vector sits at bit position k-1.
    m = (10'd1 << (a - 4'd1)) | (10'd1 << (b - 4'd1));
    return m;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [10:1]        r_g1;
  logic [10:1]        r_g2;
  logic [10:1]        r_g2_sel;
  logic [9:0]         r_chip_cnt;
  logic [9:0]         r_code_phase;
  logic signed [15:0] r_doppler;
  logic [31:0]        r_code_nco;
  logic [15:0]        r_ph;
  logic [CNT_W-1:0]   r_smp_cnt;
  logic               r_chip_fresh;

  logic               w_start_ok;
  logic               w_load;
  logic               w_strobe;
  logic               w_chip;
  logic               w_sin_neg;
  logic               w_cos_neg;
  logic               w_flip_i;
  logic               w_flip_q;
  logic [15:0]        w_ph_inc;
  logic [32:0]        w_nco_sum;
  logic [10:1]        w_g1_nxt;
  logic [10:1]        w_g2_nxt;
  logic [9:0]         w_chip_cnt_nxt;

  assign w_start_ok = start && (prn != 6'd0) && (prn <= 6'd32) && (code_phase <= CHIP_LAST);
  assign w_load     = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);
  assign w_strobe   = (r_state == S_RUN) && !stop && (r_smp_cnt == CNT_LAST);

  assign w_chip     = r_g1[10] ^ (^(r_g2 & r_g2_sel));
  assign w_sin_neg  = r_ph[15];
  assign w_cos_neg  = r_ph[15] ^ r_ph[14];
  assign w_ph_inc   = IF_STEP + r_doppler;
  assign w_nco_sum  = {1'b0, r_code_nco} + {1'b0, CODE_STEP};

  assign busy       = (r_state != S_IDLE);

  // One-chip advance of both LFSRs; chip 1022 wraps to chip 0 with all-ones reload.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_g1_nxt       = {r_g1[9:1], r_g1[3] ^ r_g1[10]};
    w_g2_nxt       = {r_g2[9:1], r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10]};
    w_chip_cnt_nxt = r_chip_cnt + 10'd1;
    if (r_chip_cnt == CHIP_LAST) begin
      w_g1_nxt       = '1;
      w_g2_nxt       = '1;
      w_chip_cnt_nxt = 10'd0;
    end
  end

  // Next-state decode: stop wins everywhere, bad start requests are dropped.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok && !stop) begin
          w_state_nxt = (code_phase != 10'd0) ? S_ADVANCE : S_RUN;
        end
      end
      S_ADVANCE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_chip_cnt == r_code_phase - 10'd1) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef GPS_SIGGEN_NOISE_EN
  logic [15:0] r_noise;

  assign w_flip_i = (r_noise[7:0]  < noise_level);
  assign w_flip_q = (r_noise[15:8] < noise_level);

  // Maximal 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), one step per strobe.
  always_ff @(posedge clk) begin
    if (!rst || w_load) begin
      r_noise <= 16'hACE1;
    end else if (w_strobe) begin
      r_noise <= {1'b0, r_noise[15:1]} ^ (r_noise[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  assign w_flip_i = 1'b0;
  assign w_flip_q = 1'b0;
`endif

  // Datapath: load on accepted start, chip skipping in ADVANCE, sample pacing in RUN.
  always_ff @(posedge clk) begin
    // NOTE: the reset clears every register; there is no memory array, so nothing is left unreset.
    if (!rst) begin
      r_g1         <= '0;
      r_g2         <= '0;
      r_g2_sel     <= '0;
      r_chip_cnt   <= '0;
      r_code_phase <= '0;
      r_doppler    <= '0;
      r_code_nco   <= '0;
      r_ph         <= '0;
      r_smp_cnt    <= '0;
      r_chip_fresh <= 1'b0;
      adc_clk      <= 1'b0;
      i_sample     <= 1'b0;
      q_sample     <= 1'b0;
      epoch        <= 1'b0;
    end else begin
      adc_clk <= 1'b0;
      epoch   <= 1'b0;
      if (w_load) begin
        r_g1         <= '1;
        r_g2         <= '1;
        r_g2_sel     <= g2_sel_mask(prn);
        r_chip_cnt   <= '0;
        r_code_phase <= code_phase;
        r_doppler    <= doppler_omega;
        r_code_nco   <= '0;
        r_ph         <= '0;
        r_smp_cnt    <= '0;
        r_chip_fresh <= 1'b1;
      end else if (r_state == S_ADVANCE && !stop) begin
        r_g1       <= w_g1_nxt;
        r_g2       <= w_g2_nxt;
        r_chip_cnt <= w_chip_cnt_nxt;
      end else if (r_state == S_RUN && !stop) begin
        if (w_strobe) begin
          r_smp_cnt    <= '0;
          adc_clk      <= 1'b1;
          i_sample     <= w_chip ^ w_cos_neg ^ w_flip_i;
          q_sample     <= w_chip ^ w_sin_neg ^ w_flip_q;
          // Epoch marks only the first sample that lands on chip 0.
          epoch        <= (r_chip_cnt == 10'd0) && r_chip_fresh;
          r_ph         <= r_ph + w_ph_inc;
          r_code_nco   <= w_nco_sum[31:0];
          r_chip_fresh <= w_nco_sum[32];
          if (w_nco_sum[32]) begin
            r_g1       <= w_g1_nxt;
            r_g2       <= w_g2_nxt;
            r_chip_cnt <= w_chip_cnt_nxt;
          end
        end else begin
          r_smp_cnt <= r_smp_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
